// File: rtl/dvi_pkg.sv
// ---------------------------------------------------------------------------
// dvi_pkg
//   Shared constants and helpers for the DVI 1.0 TMDS encoder:
//   control-period tokens, pipeline latency, running-disparity width,
//   a byte population count and the {C1,C0} -> control token mapping.
// ---------------------------------------------------------------------------
package dvi_pkg;

   localparam int unsigned TMDS_LATENCY = 3;
   localparam int unsigned DISP_W       = 6;

   // Control tokens indexed by {C1, C0}; bit 0 is transmitted first.
   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   // DC-balance decision taken for an active-video symbol.
   typedef enum logic [1:0] {
      BAL_NEUTRAL,   // cnt = 0 or q_m balanced: polarity chosen by q_m[8]
      BAL_INVERT,    // disparity would grow: send inverted q_m
      BAL_KEEP       // disparity shrinks: send q_m as is
   } tmds_bal_e;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
      logic [9:0] t;
      case ({c1, c0})
         2'b00:   t = CTRL_TOKEN_00;
         2'b01:   t = CTRL_TOKEN_01;
         2'b10:   t = CTRL_TOKEN_10;
         default: t = CTRL_TOKEN_11;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_encoder
//   One DVI 1.0 TMDS channel, 3-stage pipeline:
//     S1 registers inputs and N1(data)
//     S2 registers q_m (transition-minimised word) and N1/N0 of q_m[7:0]
//     S3 registers the 10-bit symbol and the running disparity
//   Ports:
//     clk, reset      pixel clock, asynchronous active-high reset
//     data[7:0]       pixel byte
//     de              data enable (0 = control period)
//     c0, c1          control bits encoded during blanking
//     symbol[9:0]     TMDS symbol, bit 0 transmitted first
//     disparity[5:0]  signed running-disparity counter
// ---------------------------------------------------------------------------
module tmds_channel_encoder
   import dvi_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        data,
   input  logic              de,
   input  logic              c0,
   input  logic              c1,
   output logic [9:0]        symbol,
   output logic [DISP_W-1:0] disparity
);

   localparam logic signed [DISP_W-1:0] TWO  = DISP_W'(2);
   localparam logic signed [DISP_W-1:0] ZERO = '0;

   // ---------------- S1 ----------------
   logic [7:0] data_s1_q;
   logic       de_s1_q, c0_s1_q, c1_s1_q;
   logic [3:0] n1_s1_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_s1_q <= '0;
         de_s1_q   <= 1'b0;
         c0_s1_q   <= 1'b0;
         c1_s1_q   <= 1'b0;
         n1_s1_q   <= '0;
      end else begin
         data_s1_q <= data;
         de_s1_q   <= de;
         c0_s1_q   <= c0;
         c1_s1_q   <= c1;
         n1_s1_q   <= popcount8(data);
      end
   end

   // ---------------- S2 ----------------
   logic       use_xnor;
   logic [8:0] qm_d;
   logic [3:0] qm_n1_d, qm_n0_d;

   always_comb begin
      use_xnor = (n1_s1_q > 4'd4) || ((n1_s1_q == 4'd4) && !data_s1_q[0]);
      qm_d     = '0;
      qm_d[0]  = data_s1_q[0];
      for (int unsigned i = 1; i < 8; i++) begin
         qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_s1_q[i])
                            :  (qm_d[i-1] ^ data_s1_q[i]);
      end
      qm_d[8] = ~use_xnor;
      qm_n1_d = popcount8(qm_d[7:0]);
      qm_n0_d = 4'd8 - qm_n1_d;
   end

   logic [8:0] qm_s2_q;
   logic [3:0] n1_s2_q, n0_s2_q;
   logic       de_s2_q, c0_s2_q, c1_s2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         qm_s2_q <= '0;
         n1_s2_q <= '0;
         n0_s2_q <= '0;
         de_s2_q <= 1'b0;
         c0_s2_q <= 1'b0;
         c1_s2_q <= 1'b0;
      end else begin
         qm_s2_q <= qm_d;
         n1_s2_q <= qm_n1_d;
         n0_s2_q <= qm_n0_d;
         de_s2_q <= de_s1_q;
         c0_s2_q <= c0_s1_q;
         c1_s2_q <= c1_s1_q;
      end
   end

   // ---------------- S3 ----------------
   logic signed [DISP_W-1:0] cnt_q, cnt_d, diff;
   logic [9:0]               sym_q, sym_d;
   tmds_bal_e                bal;

   always_comb begin
      // diff = N1 - N0 of q_m[7:0], widened to the counter width
      diff = $signed({{(DISP_W-4){1'b0}}, n1_s2_q})
           - $signed({{(DISP_W-4){1'b0}}, n0_s2_q});

      bal = BAL_KEEP;
      if ((cnt_q == ZERO) || (n1_s2_q == n0_s2_q)) begin
         bal = BAL_NEUTRAL;
      end else if ((!cnt_q[DISP_W-1] && (n1_s2_q > n0_s2_q)) ||
                   ( cnt_q[DISP_W-1] && (n0_s2_q > n1_s2_q))) begin
         // cnt = 0 already excluded, so a clear sign bit means cnt > 0
         bal = BAL_INVERT;
      end

      sym_d = ctrl_token(c1_s2_q, c0_s2_q);
      cnt_d = ZERO;
      if (de_s2_q) begin
         case (bal)
            BAL_NEUTRAL: begin
               sym_d = {~qm_s2_q[8], qm_s2_q[8],
                        qm_s2_q[8] ? qm_s2_q[7:0] : ~qm_s2_q[7:0]};
               cnt_d = qm_s2_q[8] ? (cnt_q + diff) : (cnt_q - diff);
            end
            BAL_INVERT: begin
               sym_d = {1'b1, qm_s2_q[8], ~qm_s2_q[7:0]};
               cnt_d = cnt_q + (qm_s2_q[8] ? TWO : ZERO) - diff;
            end
            default: begin
               sym_d = {1'b0, qm_s2_q[8], qm_s2_q[7:0]};
               cnt_d = cnt_q + diff - (qm_s2_q[8] ? ZERO : TWO);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sym_q <= CTRL_TOKEN_00;
         cnt_q <= '0;
      end else begin
         sym_q <= sym_d;
         cnt_q <= cnt_d;
      end
   end

   assign symbol    = sym_q;
   assign disparity = cnt_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// ---------------------------------------------------------------------------
// dvi_tmds_encoder
//   DVI 1.0 TMDS encoder, three channels, fixed 3-cycle latency.
//   Parameters:
//     HSYNC_INVERT / VSYNC_INVERT  invert hsync/vsync before use as C0/C1 on ch0
//   Ports:
//     dvi_clk, dvi_reset   pixel clock, asynchronous active-high reset
//     dvi_rgb[31:0]        [7:0] red, [15:8] green, [23:16] blue, [31:24] unused
//     dvi_hsync/vsync      syncs from the timing generator
//     dvi_active_video     data enable
//     tmds_ch0/1/2         blue+sync / green / red symbols, bit 0 first
//     dbg_disparity        {ch2, ch1, ch0} signed running-disparity counters
// ---------------------------------------------------------------------------
module dvi_tmds_encoder
   import dvi_pkg::*;
#(
   parameter logic HSYNC_INVERT = 1'b0,
   parameter logic VSYNC_INVERT = 1'b0
)(
   input  logic                dvi_clk,
   input  logic                dvi_reset,
   input  logic [31:0]         dvi_rgb,
   input  logic                dvi_hsync,
   input  logic                dvi_vsync,
   input  logic                dvi_active_video,
   output logic [9:0]          tmds_ch0,
   output logic [9:0]          tmds_ch1,
   output logic [9:0]          tmds_ch2,
   output logic [3*DISP_W-1:0] dbg_disparity
);

   logic [7:0]        rgb_pad_unused;
   logic              c0_ch0, c1_ch0;
   logic [DISP_W-1:0] disp_ch0, disp_ch1, disp_ch2;

   assign rgb_pad_unused = dvi_rgb[31:24];
   assign c0_ch0         = dvi_hsync ^ HSYNC_INVERT;
   assign c1_ch0         = dvi_vsync ^ VSYNC_INVERT;

   tmds_channel_encoder u_ch0 (
      .clk       (dvi_clk),
      .reset     (dvi_reset),
      .data      (dvi_rgb[23:16]),
      .de        (dvi_active_video),
      .c0        (c0_ch0),
      .c1        (c1_ch0),
      .symbol    (tmds_ch0),
      .disparity (disp_ch0)
   );

   tmds_channel_encoder u_ch1 (
      .clk       (dvi_clk),
      .reset     (dvi_reset),
      .data      (dvi_rgb[15:8]),
      .de        (dvi_active_video),
      .c0        (1'b0),
      .c1        (1'b0),
      .symbol    (tmds_ch1),
      .disparity (disp_ch1)
   );

   tmds_channel_encoder u_ch2 (
      .clk       (dvi_clk),
      .reset     (dvi_reset),
      .data      (dvi_rgb[7:0]),
      .de        (dvi_active_video),
      .c0        (1'b0),
      .c1        (1'b0),
      .symbol    (tmds_ch2),
      .disparity (disp_ch2)
   );

   assign dbg_disparity = {disp_ch2, disp_ch1, disp_ch0};

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
module tb_dvi_tmds_encoder;
   import dvi_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rgb;
   logic        hs, vs, de;
   logic [9:0]  ch0, ch1, ch2, ich0, ich1, ich2;
   logic [17:0] disp, idisp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dvi_tmds_encoder dut (
      .dvi_clk          (clk),
      .dvi_reset        (rst),
      .dvi_rgb          (rgb),
      .dvi_hsync        (hs),
      .dvi_vsync        (vs),
      .dvi_active_video (de),
      .tmds_ch0         (ch0),
      .tmds_ch1         (ch1),
      .tmds_ch2         (ch2),
      .dbg_disparity    (disp)
   );

   dvi_tmds_encoder #(.HSYNC_INVERT(1'b1), .VSYNC_INVERT(1'b0)) dut_inv (
      .dvi_clk          (clk),
      .dvi_reset        (rst),
      .dvi_rgb          (rgb),
      .dvi_hsync        (hs),
      .dvi_vsync        (vs),
      .dvi_active_video (de),
      .tmds_ch0         (ich0),
      .tmds_ch1         (ich1),
      .tmds_ch2         (ich2),
      .dbg_disparity    (idisp)
   );

   task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chkbound(input string name, input int v);
      checks++;
      if (v > 10 || v < -10) begin
         errors++;
         $display("FAIL %s: got %0d expected within -10..10", name, v);
      end
   endtask

   function automatic int sd(input logic [5:0] v);
      return int'($signed(v));
   endfunction

   // Reference DVI 1.0 encoder for one channel and one cycle.
   function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic den,
                                          input logic c1, input logic c0,
                                          input int cin, output int cout);
      logic [9:0] s;
      logic [8:0] q;
      logic       xn;
      int         ones, a, b;
      q = '0;
      if (!den) begin
         cout = 0;
         case ({c1, c0})
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
         endcase
      end else begin
         ones = $countones(d);
         xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
         q[0] = d[0];
         for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
         q[8] = ~xn;
         a = $countones(q[7:0]);
         b = 8 - a;
         if (cin == 0 || a == b) begin
            s    = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cout = q[8] ? cin + a - b : cin + b - a;
         end else if ((cin > 0 && a > b) || (cin < 0 && b > a)) begin
            s    = {1'b1, q[8], ~q[7:0]};
            cout = cin + (q[8] ? 2 : 0) + b - a;
         end else begin
            s    = {1'b0, q[8], q[7:0]};
            cout = cin + a - b - (q[8] ? 0 : 2);
         end
      end
      return s;
   endfunction

   function automatic logic [7:0] tmds_decode(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   typedef struct {
      logic       de, hs, vs;
      logic [7:0] b, g, r;
      logic [9:0] e0, e1, e2, ei0;
      int         c0, c1, c2;
   } vec_t;

   localparam int NV = 10;
   localparam int NS = 2000;
   vec_t vt[NV];

   logic [9:0] xs0[NS], xs1[NS], xs2[NS], xi0[NS];
   logic [7:0] xb[NS], xg[NS], xr[NS];
   logic       xde[NS];
   int         xc0[NS], xc1[NS], xc2[NS];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m0, m1, m2, mi, n0, n1, n2, ni;

      //          de   hs   vs   blue   green  red    ch0     ch1     ch2     inv ch0  cnt0 cnt1 cnt2
      vt[0] = '{1'b0,1'b0,1'b0,8'h00,8'h00,8'h00,10'h354,10'h354,10'h354,10'h0AB, 0, 0, 0};
      vt[1] = '{1'b0,1'b1,1'b0,8'h00,8'h00,8'h00,10'h0AB,10'h354,10'h354,10'h354, 0, 0, 0};
      vt[2] = '{1'b0,1'b0,1'b1,8'h00,8'h00,8'h00,10'h154,10'h354,10'h354,10'h2AB, 0, 0, 0};
      vt[3] = '{1'b0,1'b1,1'b1,8'h00,8'h00,8'h00,10'h2AB,10'h354,10'h354,10'h154, 0, 0, 0};
      vt[4] = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'hFF,10'h100,10'h100,10'h200,10'h100,-8,-8,-8};
      vt[5] = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'hFF,10'h3FF,10'h3FF,10'h0FF,10'h3FF, 2, 2,-2};
      vt[6] = '{1'b1,1'b0,1'b0,8'h00,8'h10,8'h00,10'h100,10'h1F0,10'h3FF,10'h100,-6, 2, 8};
      vt[7] = '{1'b0,1'b1,1'b0,8'h00,8'h00,8'h00,10'h0AB,10'h354,10'h354,10'h354, 0, 0, 0};
      vt[8] = '{1'b1,1'b0,1'b0,8'h00,8'h00,8'hFF,10'h100,10'h100,10'h200,10'h100,-8,-8,-8};
      vt[9] = '{1'b1,1'b0,1'b0,8'hFF,8'h55,8'h01,10'h0FF,10'h133,10'h1FF,10'h0FF,-2,-8, 0};

      // Reset asserted with DE high: outputs settle without any clock edge.
      rst = 1'b0; rgb = 32'h0012_3456; hs = 1'b1; vs = 1'b1; de = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk10("reset ch0", ch0, 10'h354);
      chk10("reset ch1", ch1, 10'h354);
      chk10("reset ch2", ch2, 10'h354);
      chk10("reset inv ch0", ich0, 10'h354);
      chki("reset disparity", int'(disp), 0);
      repeat (2) @(negedge clk);

      // Table: vector j driven at negedge j, its symbols read 3 negedges later.
      for (int j = 0; j < NV + TMDS_LATENCY; j++) begin
         @(negedge clk);
         if (j >= TMDS_LATENCY) begin
            int k;
            k = j - TMDS_LATENCY;
            chk10($sformatf("vec%0d ch0", k), ch0, vt[k].e0);
            chk10($sformatf("vec%0d ch1", k), ch1, vt[k].e1);
            chk10($sformatf("vec%0d ch2", k), ch2, vt[k].e2);
            chk10($sformatf("vec%0d inv ch0", k), ich0, vt[k].ei0);
            chk10($sformatf("vec%0d inv ch1", k), ich1, vt[k].e1);
            chki($sformatf("vec%0d cnt0", k), sd(disp[5:0]), vt[k].c0);
            chki($sformatf("vec%0d cnt1", k), sd(disp[11:6]), vt[k].c1);
            chki($sformatf("vec%0d cnt2", k), sd(disp[17:12]), vt[k].c2);
         end
         if (j == 0) rst = 1'b0;
         if (j < NV) begin
            de = vt[j].de; hs = vt[j].hs; vs = vt[j].vs;
            rgb = {8'hA5, vt[j].b, vt[j].g, vt[j].r};
         end else begin
            de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0;
         end
      end

      // Three consecutive blue = 0x00 from a cleared counter.
      repeat (2) @(negedge clk);
      de = 1'b1; rgb = 32'h0000_0000; hs = 1'b0; vs = 1'b0;
      repeat (3) @(negedge clk);
      chk10("blue0 #1 ch0", ch0, 10'h100); chki("blue0 #1 cnt", sd(disp[5:0]), -8);
      @(negedge clk);
      chk10("blue0 #2 ch0", ch0, 10'h3FF); chki("blue0 #2 cnt", sd(disp[5:0]), 2);
      @(negedge clk);
      chk10("blue0 #3 ch0", ch0, 10'h100); chki("blue0 #3 cnt", sd(disp[5:0]), -6);

      // Reset mid-line with nonzero disparity and data in flight.
      #2 rst = 1'b1;
      #1;
      chk10("midreset ch0", ch0, 10'h354);
      chk10("midreset ch1", ch1, 10'h354);
      chk10("midreset ch2", ch2, 10'h354);
      chki("midreset disparity", int'(disp), 0);
      chki("midreset inv disparity", int'(idisp), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk10("release +1 ch0", ch0, 10'h354);
      @(negedge clk);
      chk10("release +2 ch0", ch0, 10'h354);
      @(negedge clk);
      chk10("release +3 ch0", ch0, 10'h100);
      chki("release +3 cnt0", sd(disp[5:0]), -8);

      // Blanking to clear disparity, then randomised sweep against the model.
      de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0;
      repeat (4) @(negedge clk);
      m0 = 0; m1 = 0; m2 = 0; mi = 0;
      for (int j = 0; j < NS + TMDS_LATENCY; j++) begin
         @(negedge clk);
         if (j >= TMDS_LATENCY) begin
            int k;
            k = j - TMDS_LATENCY;
            chk10($sformatf("sweep%0d ch0", k), ch0, xs0[k]);
            chk10($sformatf("sweep%0d ch1", k), ch1, xs1[k]);
            chk10($sformatf("sweep%0d ch2", k), ch2, xs2[k]);
            chk10($sformatf("sweep%0d inv ch0", k), ich0, xi0[k]);
            chki($sformatf("sweep%0d cnt0", k), sd(disp[5:0]), xc0[k]);
            chki($sformatf("sweep%0d cnt1", k), sd(disp[11:6]), xc1[k]);
            chki($sformatf("sweep%0d cnt2", k), sd(disp[17:12]), xc2[k]);
            chkbound($sformatf("sweep%0d bound0", k), sd(disp[5:0]));
            chkbound($sformatf("sweep%0d bound1", k), sd(disp[11:6]));
            chkbound($sformatf("sweep%0d bound2", k), sd(disp[17:12]));
            if (xde[k]) begin
               chki($sformatf("sweep%0d decode0", k), int'(tmds_decode(ch0)), int'(xb[k]));
               chki($sformatf("sweep%0d decode1", k), int'(tmds_decode(ch1)), int'(xg[k]));
               chki($sformatf("sweep%0d decode2", k), int'(tmds_decode(ch2)), int'(xr[k]));
            end
         end
         if (j < NS) begin
            de  = ($urandom_range(0, 9) < 8);
            hs  = 1'($urandom_range(0, 1));
            vs  = 1'($urandom_range(0, 1));
            rgb = $urandom;
            xde[j] = de;
            xb[j]  = rgb[23:16];
            xg[j]  = rgb[15:8];
            xr[j]  = rgb[7:0];
            xs0[j] = ref_enc(rgb[23:16], de, vs, hs, m0, n0);
            xs1[j] = ref_enc(rgb[15:8], de, 1'b0, 1'b0, m1, n1);
            xs2[j] = ref_enc(rgb[7:0], de, 1'b0, 1'b0, m2, n2);
            xi0[j] = ref_enc(rgb[23:16], de, vs, ~hs, mi, ni);
            m0 = n0; m1 = n1; m2 = n2; mi = ni;
            xc0[j] = m0; xc1[j] = m1; xc2[j] = m2;
         end else begin
            de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = '0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
